// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer for a single-port 8-bit
// data memory. Port A is the control unit's data path, port B a secondary
// master (loader / debug DMA). One access at a time: IDLE -> ACCESS for
// MEM_LATENCY cycles -> DONE (one-cycle ack) -> IDLE.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,    // legal 1..15
    parameter bit FIXED_PRIO  = 1'b0  // 0: round-robin, 1: A wins ties
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    output logic       a_ack,

    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic [7:0] b_rdata,
    output logic       b_ack,

    output logic       mem_en,
    output logic [7:0] mem_cmd,
    output logic [7:0] mem_addr,
    inout  wire  [7:0] mem_data,

    output logic       busy,
    output logic       owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    // Final ACCESS count; cnt stops here so it can never wrap.
    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;

    // 1 when B received the most recent grant; reset to B so A wins the
    // first tie under round-robin.
    logic       last_b;

    logic       any_req;
    logic       grant_b;
    logic       start;
    logic       finish;

    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    logic       cur_we;
    logic [7:0] cur_wdata;
    logic       drive_en;

    assign any_req = a_req | b_req;
    assign start   = (state == S_IDLE) && any_req;
    assign finish  = (state == S_ACCESS) && (cnt == CNT_LAST);

    // Winner selection: a lone requester wins, ties go by priority mode.
    always_comb begin
        grant_b = 1'b0;
        if (b_req && !a_req) begin
            grant_b = 1'b1;
        end else if (a_req && b_req && !FIXED_PRIO) begin
            grant_b = !last_b;
        end
    end

    // Route the winner's request fields toward the latch.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_b) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Sequencer next state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Access latency counter, cleared on grant and held at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= 4'd0;
        end else if (state == S_ACCESS && cnt != CNT_LAST) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Grant pointer and owner move only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
            owner  <= 1'b0;
        end else if (start) begin
            last_b <= grant_b;
            owner  <= grant_b;
        end
    end

    // Capture the winner's request; later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_we    <= 1'b0;
            cur_wdata <= 8'h00;
            mem_addr  <= 8'h00;
        end else if (start) begin
            cur_we    <= sel_we;
            cur_wdata <= sel_wdata;
            mem_addr  <= sel_addr;
        end
    end

    // Memory strobe, command and bus drive enable, held for all of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_cmd  <= CMD_READ;
            drive_en <= 1'b0;
        end else if (start) begin
            mem_en   <= 1'b1;
            mem_cmd  <= sel_we ? CMD_WRITE : CMD_READ;
            drive_en <= sel_we;
        end else if (finish) begin
            mem_en   <= 1'b0;
            mem_cmd  <= CMD_READ;
            drive_en <= 1'b0;
        end
    end

    // Read capture on the last ACCESS edge plus the one-cycle ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
        end else begin
            a_ack <= finish && !owner;
            b_ack <= finish && owner;
            if (finish && !cur_we) begin
                if (owner) begin
                    b_rdata <= mem_data;
                end else begin
                    a_rdata <= mem_data;
                end
            end
        end
    end

    // busy covers ACCESS and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == S_ACCESS) || (state_nxt == S_DONE);
        end
    end

    // Bus is driven only while a granted write is in ACCESS.
    assign mem_data = drive_en ? cur_wdata : 8'bz;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (L=1 round-robin, L=1 fixed
// priority, L=3 round-robin), each with its own memory model on its bus.
// The memory model parks the bus at 8'hC3 whenever no access is active,
// so any stray arbiter drive shows up as a corrupted bus value.
module tb_dmem_arbiter;

    localparam int NC = 3;
    localparam logic [7:0] PARK = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NC-1:0]      a_req, a_we, b_req, b_we;
    logic [NC-1:0][7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [NC-1:0][7:0] a_rdata, b_rdata, mem_cmd, mem_addr;
    logic [NC-1:0]      a_ack, b_ack, mem_en, busy, owner;
    logic [7:0]         bus_obs [NC];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit fp_of(input int k);
        return (k == 1);
    endfunction

    for (genvar g = 0; g < NC; g++) begin : g_dut
        wire  [7:0] bus;
        logic [7:0] mem [256];
        logic       drv;
        logic [7:0] val;

        initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h96;

        always @(posedge clk)
            if (mem_en[g] && mem_cmd[g] == 8'h01) mem[mem_addr[g]] <= bus;

        assign drv = !(mem_en[g] && mem_cmd[g] == 8'h01);
        assign val = mem_en[g] ? mem[mem_addr[g]] : PARK;
        assign bus = drv ? val : 8'bz;
        assign bus_obs[g] = bus;

        dmem_arbiter #(.MEM_LATENCY((g == 2) ? 3 : 1), .FIXED_PRIO(g == 1)) u_dut (
            .clk(clk), .rst(rst),
            .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_rdata(a_rdata[g]), .a_ack(a_ack[g]),
            .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .b_rdata(b_rdata[g]), .b_ack(b_ack[g]),
            .mem_en(mem_en[g]), .mem_cmd(mem_cmd[g]), .mem_addr(mem_addr[g]),
            .mem_data(bus), .busy(busy[g]), .owner(owner[g])
        );
    end

    // Reference memory contents, updated when a write is granted.
    logic [7:0] ref_mem [NC][256];

    // Random-phase transaction model state.
    int         nsamp [NC];
    int         gedge [NC];
    bit         gown [NC], gwe [NC], lastb [NC];
    logic [7:0] gaddr [NC], gwd [NC], exp_ra [NC], exp_rb [NC];

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_ra;
        logic [7:0] exp_rb;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input bit port, input bit r, input bit we,
                           input logic [7:0] ad, input logic [7:0] wd);
        if (port) begin
            b_req[k] = r; b_we[k] = we; b_addr[k] = ad; b_wdata[k] = wd;
        end else begin
            a_req[k] = r; a_we[k] = we; a_addr[k] = ad; a_wdata[k] = wd;
        end
    endtask

    task automatic chk_idle(input string nm, input int k);
        chk({nm, "_mem_en"}, k, mem_en[k], 0);
        chk({nm, "_cmd"}, k, mem_cmd[k], 8'h00);
        chk({nm, "_busy"}, k, busy[k], 0);
        chk({nm, "_acks"}, k, {a_ack[k], b_ack[k]}, 2'b00);
        chk({nm, "_bus"}, k, bus_obs[k], PARK);
    endtask

    task automatic do_reset();
        a_req = '0; b_req = '0; rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NC; k++) begin
            chk_idle("rst", k);
            chk("rst_rdata", k, {a_rdata[k], b_rdata[k]}, 16'h0000);
            chk("rst_addr", k, mem_addr[k], 8'h00);
            chk("rst_owner", k, owner[k], 0);
        end
    endtask

    // One complete access on port 'port' of instance k, starting and ending
    // at a negedge with the arbiter idle.
    task automatic run_txn(input int k, input bit port, input bit we, input logic [7:0] addr,
                           input logic [7:0] wd, input logic [7:0] era, input logic [7:0] erb);
        int n;
        bit got;
        n = 0;
        got = 0;
        set_req(k, port, 1'b1, we, addr, wd);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (a_ack[k] || b_ack[k]) begin
                got = 1;
            end else begin
                chk("acc_mem_en", k, mem_en[k], 1);
                chk("acc_cmd", k, mem_cmd[k], {7'd0, we});
                chk("acc_addr", k, mem_addr[k], addr);
                chk("acc_busy_owner", k, {busy[k], owner[k]}, {1'b1, port});
                chk("acc_bus", k, bus_obs[k], we ? wd : ref_mem[k][addr]);
                // Fields change after grant; they must have no effect.
                set_req(k, port, 1'b1, !we, ~addr, ~wd);
            end
        end
        chk("ack_latency", k, n, lat_of(k) + 1);
        chk("ack_port", k, {a_ack[k], b_ack[k]}, port ? 2'b01 : 2'b10);
        chk("done_busy_owner", k, {busy[k], owner[k]}, {1'b1, port});
        chk("done_mem_en", k, mem_en[k], 0);
        chk("done_cmd", k, mem_cmd[k], 8'h00);
        chk("done_bus", k, bus_obs[k], PARK);
        if (we) ref_mem[k][addr] = wd;
        chk("rdata_a", k, a_rdata[k], era);
        chk("rdata_b", k, b_rdata[k], erb);
        set_req(k, port, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_idle("post", k);
        chk("post_rdata", k, {a_rdata[k], b_rdata[k]}, {era, erb});
    endtask

    // Both ports hold requests; checks the owner of each ack, spacing and data.
    // In fixed-priority mode A drops after its 3rd ack so B gets in.
    task automatic tie_seq(input int k, input int nacks, input int a_drop_after);
        int n, na, last, exp_o;
        n = 0; na = 0; last = -1;
        set_req(k, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(k, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        while (na < nacks && n < 60) begin
            @(negedge clk);
            n++;
            if (a_ack[k] || b_ack[k]) begin
                if (fp_of(k)) exp_o = (na < a_drop_after) ? 0 : 1;
                else          exp_o = na % 2;
                chk("tie_owner", k, owner[k], exp_o);
                chk("tie_ackport", k, {a_ack[k], b_ack[k]}, exp_o ? 2'b01 : 2'b10);
                if (last >= 0) chk("tie_spacing", k, n - last, lat_of(k) + 2);
                if (exp_o) chk("tie_rdata_b", k, b_rdata[k], 8'h94);
                else       chk("tie_rdata_a", k, a_rdata[k], 8'h97);
                last = n;
                na++;
                if (na == a_drop_after) a_req[k] = 1'b0;
            end
        end
        chk("tie_count", k, na, nacks);
        a_req[k] = 1'b0;
        b_req[k] = 1'b0;
    endtask

    task automatic rand_fields(input int k, input bit port);
        set_req(k, port, port ? b_req[k] : a_req[k], 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), 8'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        for (int k = 0; k < NC; k++)
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'(i) ^ 8'h96;

        tbl[0]  = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h5A};
        tbl[2]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A};
        tbl[3]  = '{1'b1, 1'b1, 8'h22, 8'hC0, 8'h5A, 8'h5A};
        tbl[4]  = '{1'b0, 1'b0, 8'h22, 8'h00, 8'hC0, 8'h5A};
        tbl[5]  = '{1'b1, 1'b1, 8'h10, 8'hFF, 8'hC0, 8'h5A};
        tbl[6]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hC0, 8'hFF};
        tbl[7]  = '{1'b0, 1'b0, 8'h33, 8'h00, 8'hA5, 8'hFF};
        tbl[8]  = '{1'b1, 1'b0, 8'h7F, 8'h00, 8'hA5, 8'hE9};
        tbl[9]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'hA5, 8'hE9};
        tbl[10] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h01, 8'hE9};

        do_reset();
        for (int i = 0; i < 11; i++)
            run_txn(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_ra, tbl[i].exp_rb);

        // Round-robin ties: A,B,A,B.
        do_reset();
        tie_seq(0, 4, 99);
        // Fixed priority: A three times, then B only once A lets go.
        do_reset();
        tie_seq(1, 4, 3);
        // Long latency read.
        do_reset();
        run_txn(2, 1'b0, 1'b0, 8'h20, 8'h00, 8'hB6, 8'h00);

        // Randomized traffic on all instances against the transaction model.
        do_reset();
        for (int k = 0; k < NC; k++) begin
            nsamp[k] = 1; gedge[k] = -1000; lastb[k] = 1'b1;
            exp_ra[k] = 8'h00; exp_rb[k] = 8'h00;
        end
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            for (int k = 0; k < NC; k++) begin
                int  L, ph;
                bit  acc, dn, wb;
                L = lat_of(k);
                if (n == gedge[k] + L && !gwe[k]) begin
                    if (gown[k]) exp_rb[k] = ref_mem[k][gaddr[k]];
                    else         exp_ra[k] = ref_mem[k][gaddr[k]];
                end
                if (n == nsamp[k]) begin
                    if (a_req[k] || b_req[k]) begin
                        wb = b_req[k] && (!a_req[k] || (!fp_of(k) && !lastb[k]));
                        gedge[k] = n;
                        gown[k]  = wb;
                        gwe[k]   = wb ? b_we[k] : a_we[k];
                        gaddr[k] = wb ? b_addr[k] : a_addr[k];
                        gwd[k]   = wb ? b_wdata[k] : a_wdata[k];
                        lastb[k] = wb;
                        if (gwe[k]) ref_mem[k][gaddr[k]] = gwd[k];
                        nsamp[k] = n + L + 2;
                    end else begin
                        nsamp[k] = n + 1;
                    end
                end
                ph  = n - gedge[k];
                acc = (ph >= 0) && (ph < L);
                dn  = (ph == L);
                chk("rnd_mem_en", k, mem_en[k], acc);
                chk("rnd_busy", k, busy[k], acc || dn);
                chk("rnd_acks", k, {a_ack[k], b_ack[k]}, {dn && !gown[k], dn && gown[k]});
                if (acc) begin
                    chk("rnd_cmd", k, mem_cmd[k], {7'd0, gwe[k]});
                    chk("rnd_addr", k, mem_addr[k], gaddr[k]);
                    chk("rnd_bus", k, bus_obs[k], gwe[k] ? gwd[k] : ref_mem[k][gaddr[k]]);
                end else begin
                    chk("rnd_cmd_idle", k, mem_cmd[k], 8'h00);
                    chk("rnd_bus_idle", k, bus_obs[k], PARK);
                end
                if (acc || dn) chk("rnd_owner", k, owner[k], gown[k]);
                chk("rnd_rdata", k, {a_rdata[k], b_rdata[k]}, {exp_ra[k], exp_rb[k]});

                if (a_req[k]) begin
                    if (a_ack[k] && $urandom_range(0, 1) == 0) a_req[k] = 1'b0;
                    else if (a_ack[k] || $urandom_range(0, 3) == 0) rand_fields(k, 1'b0);
                end else if ($urandom_range(0, 2) == 0) begin
                    a_req[k] = 1'b1;
                    rand_fields(k, 1'b0);
                end
                if (b_req[k]) begin
                    if (b_ack[k] && $urandom_range(0, 1) == 0) b_req[k] = 1'b0;
                    else if (b_ack[k] || $urandom_range(0, 3) == 0) rand_fields(k, 1'b1);
                end else if ($urandom_range(0, 2) == 0) begin
                    b_req[k] = 1'b1;
                    rand_fields(k, 1'b1);
                end
            end
        end
        a_req = '0; b_req = '0;
        repeat (6) @(negedge clk);

        // Reset during a B write: abort, no ack, bus released, pointer back to B.
        do_reset();
        run_txn(2, 1'b0, 1'b1, 8'h40, 8'h77, 8'h00, 8'h00);
        set_req(2, 1'b1, 1'b1, 1'b1, 8'h50, 8'h99);
        @(negedge clk);
        chk("abort_pre_en", 2, mem_en[2], 1);
        chk("abort_pre_owner", 2, owner[2], 1);
        chk("abort_pre_bus", 2, bus_obs[2], 8'h99);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort", 2);
        rst = 1'b0;
        set_req(2, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        begin
            int n;
            bit got;
            n = 0;
            got = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                if (a_ack[2] || b_ack[2]) got = 1;
            end
            chk("abort_first_latency", 2, n, 4);
            chk("abort_first_port", 2, {a_ack[2], b_ack[2]}, 2'b10);
            chk("abort_first_owner", 2, owner[2], 0);
            chk("abort_first_rdata", 2, a_rdata[2], 8'hB6);
        end
        a_req = '0; b_req = '0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 8-bit data memory (cmd/addr/bidirectional data bus).
- Port A is the control unit's data-memory path; port B is a secondary master (program loader / debug DMA).
- Serialises accesses, drives and releases the shared tri-state data bus, and returns read data with a one-cycle acknowledge pulse.

Parameters:
- MEM_LATENCY, 1: cycles the memory command/address/data are held before read data is captured; legal 1..15.
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A always wins a tie.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- a_req  in  1  A request; held high until a_ack
- a_we  in  1  A write enable (1 write, 0 read)
- a_addr  in  8  A address
- a_wdata  in  8  A write data
- a_rdata  out  8  A read data, registered
- a_ack  out  1  A completion pulse, 1 cycle
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack  same as A, for port B
- mem_en  out  1  memory access strobe
- mem_cmd  out  8  8'h00 read, 8'h01 write
- mem_addr  out  8  memory address
- mem_data  inout  8  shared data bus; driven only during a granted write, else 8'bz
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = A, 1 = B; valid while busy

Behaviour:
- Reset (synchronous, active-high, one clock): state IDLE, a_ack/b_ack 0, a_rdata/b_rdata 8'h00, mem_en 0, mem_cmd 8'h00, mem_addr 8'h00, mem_data released (z), busy 0, owner 0, last-grant pointer = B so A wins the first tie.
- Reset mid-transaction: the transaction is aborted, no ack is issued, and the bus is released the cycle after reset is sampled. A write in flight has undefined memory effect.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on a posedge with any req high:
  - Select winner, then latch its we/addr/wdata.
  - Drive mem_en=1, mem_cmd=we, mem_addr; drive mem_data only if write.
  - Set owner, load cnt=0, go to ACCESS.
  - With no req, stay in IDLE with outputs quiescent.
- Arbitration:
  - Only one requester: that one wins.
  - Both requesting, FIXED_PRIO=1: A wins.
  - Both requesting, FIXED_PRIO=0: the requester not granted last wins.
  - Pointer updates only on grant.
- ACCESS: memory signals held stable. At each posedge, if cnt==MEM_LATENCY-1:
  - Read: capture mem_data into the owner's rdata.
  - Assert the owner's ack, drop mem_en, set mem_cmd to 8'h00, release the bus, go to DONE.
  - Otherwise cnt++.
- DONE: ack high for exactly this cycle, then return to IDLE; ack drops.
- Requester handshake:
  - Deassert req at the posedge ending the ack cycle. Arbitration in the following IDLE cycle sees the new req value.
  - A req still high then is a new request.
- Latency: req sampled at edge T gives ack high during cycle T+MEM_LATENCY+1. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Request signal stability: req/we/addr/wdata changes while not granted are ignored until the next IDLE sample. Changes after grant have no effect.
- rdata retention: a port's rdata holds its last read value. It is unchanged by writes and by the other port's reads.
- Bus contention: the bus is never driven by the arbiter in IDLE or DONE, or during reads.
- Width rules: all paths 8-bit, no arithmetic except the 4-bit cnt, which never wraps.

Test Plan:
- Reset, then A write addr 8'h10 data 8'h5A (MEM_LATENCY=1) -> mem_en/mem_cmd=8'h01/mem_addr=8'h10/mem_data=8'h5A for 1 cycle; a_ack pulse 2 cycles after req sample; bus z afterwards.
- B read addr 8'h10 with memory model returning 8'h5A -> b_rdata=8'h5A when b_ack is high; a_rdata unchanged at 8'h00.
- A and B request together from reset, FIXED_PRIO=0, both held -> grant order A,B,A,B; each ack separated by 3 cycles; owner toggles.
- Same stimulus with FIXED_PRIO=1 and A re-requesting immediately -> B never granted while A is requesting; B granted only in the IDLE where a_req is low.
- MEM_LATENCY=3, A read addr 8'h20 -> mem signals stable 3 cycles; a_ack in cycle T+4; data captured on the last ACCESS edge.
- rst asserted during ACCESS of a B write -> next cycle mem_en=0, bus z, no b_ack, state IDLE; a subsequent A request is granted first.
